mvu_rdc_reader: RTL and testbench

Result-readout engine on the downstream side of one MVU's data memory port. Accepts a burst command (base address, word count), issues `rdc_en`/`rdc_addr` read requests, collects `rdc_word` after each grant and streams results out through a small FIFO with a valid/ready handshake. Instantiate one per MVU (NMVU copies) between the MVU `rdc_*` port and the host/testbench result sink.

---
 rtl/mvu_rdc_reader_pkg.sv | 17 +
 rtl/mvu_rdc_reader_fifo.sv | 61 ++++++
 rtl/mvu_rdc_reader.sv | 137 +++++++++++++
 tb/tb_mvu_rdc_reader.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_rdc_reader_pkg.sv
// Shared types and constants for the MVU result-readout engine.
// Default widths mirror the MVU data-memory port.
package mvu_rdc_reader_pkg;

  localparam int MVU_BDBANKA    = 15;
  localparam int MVU_BDBANKW    = 64;
  localparam int RDC_FIFO_DEPTH = 4;
  localparam int RDC_LEN_W      = 16;

  typedef enum logic [1:0] {
    RDC_IDLE  = 2'd0,
    RDC_REQ   = 2'd1,
    RDC_DRAIN = 2'd2,
    RDC_DONE  = 2'd3
  } rdc_rd_state_t;

endpackage

// File: rtl/mvu_rdc_reader_fifo.sv
// Small synchronous FIFO holding {last, word} results; head is read straight from storage
// registers (no fall-through), occupancy exported for the request credit check.
module mvu_rdc_reader_fifo #(
  parameter  int W     = 65,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign pop_ok_s  = pop && (count_r != '0);
  // A full FIFO may still accept a push in the same cycle as a pop.
  assign push_ok_s = push && (!full_s || pop_ok_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign valid = (count_r != '0);
  assign count = count_r;

endmodule

// File: rtl/mvu_rdc_reader.sv
// Burst readout engine: issues rdc_en/rdc_addr requests to one MVU data memory,
// captures rdc_word the cycle after each grant and streams it out via a FIFO.
module mvu_rdc_reader
  import mvu_rdc_reader_pkg::*;
#(
  parameter int BDBANKA    = MVU_BDBANKA,
  parameter int BDBANKW    = MVU_BDBANKW,
  parameter int FIFO_DEPTH = RDC_FIFO_DEPTH,
  parameter int LEN_W      = RDC_LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [BDBANKA-1:0] cmd_baddr,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic               rdc_en,
  output logic [BDBANKA-1:0] rdc_addr,
  input  logic               rdc_grnt,
  input  logic [BDBANKW-1:0] rdc_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BDBANKW-1:0] out_word,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rdc_rd_state_t      state_r;
  rdc_rd_state_t      state_nxt_s;
  logic [BDBANKA-1:0] addr_r;
  logic [LEN_W-1:0]   remain_r;
  logic               inflight_r;
  logic               inflight_last_r;
  logic [CW-1:0]      fifo_count_s;
  logic [BDBANKW:0]   fifo_head_s;
  logic               fifo_valid_s;
  logic               credit_ok_s;
  logic               rdc_en_s;
  logic               grant_s;
  logic               last_grant_s;
  logic               accept_s;
  logic               pop_s;

  // Words already buffered plus the one in flight must leave room for another request.
  assign credit_ok_s  = ({1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_r}) < (CW+1)'(FIFO_DEPTH);
  assign rdc_en_s     = (state_r == RDC_REQ) && credit_ok_s;
  assign grant_s      = rdc_en_s && rdc_grnt;
  assign last_grant_s = grant_s && (remain_r == LEN_W'(1));
  assign accept_s     = (state_r == RDC_IDLE) && cmd_valid;
  assign pop_s        = fifo_valid_s && out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RDC_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; DRAIN ends on the cycle the last-tagged word is handed off.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RDC_IDLE: begin
        if (cmd_valid) begin
          state_nxt_s = (cmd_len == '0) ? RDC_DONE : RDC_REQ;
        end else begin
          state_nxt_s = RDC_IDLE;
        end
      end
      RDC_REQ: begin
        if (last_grant_s) begin
          state_nxt_s = RDC_DRAIN;
        end else begin
          state_nxt_s = RDC_REQ;
        end
      end
      RDC_DRAIN: begin
        if (pop_s && fifo_head_s[BDBANKW]) begin
          state_nxt_s = RDC_DONE;
        end else begin
          state_nxt_s = RDC_DRAIN;
        end
      end
      RDC_DONE: state_nxt_s = RDC_IDLE;
      default:  state_nxt_s = RDC_IDLE;
    endcase
  end

  // Address/length counters and the one-cycle inflight marker for returning data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r          <= '0;
      remain_r        <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r   <= cmd_baddr;
        remain_r <= cmd_len;
      end else if (grant_s) begin
        addr_r   <= addr_r + BDBANKA'(1);
        remain_r <= remain_r - LEN_W'(1);
      end
      inflight_r      <= grant_s;
      inflight_last_r <= last_grant_s;
    end
  end

  mvu_rdc_reader_fifo #(
    .W     (BDBANKW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data ({inflight_last_r, rdc_word}),
    .pop       (out_ready),
    .head      (fifo_head_s),
    .valid     (fifo_valid_s),
    .count     (fifo_count_s)
  );

  assign cmd_ready = (state_r == RDC_IDLE);
  assign rdc_en    = rdc_en_s;
  assign rdc_addr  = addr_r;
  assign out_valid = fifo_valid_s;
  assign out_word  = fifo_head_s[BDBANKW-1:0];
  assign out_last  = fifo_head_s[BDBANKW];
  assign busy      = (state_r != RDC_IDLE);
  assign done      = (state_r == RDC_DONE);

endmodule

// File: tb/tb_mvu_rdc_reader.sv
// Self-checking bench for mvu_rdc_reader: an MVU memory/sink model drives grants, data and
// out_ready; each burst is compared against an address/data stream computed from the command.
module tb_mvu_rdc_reader;

  localparam int AW = 15;
  localparam int DW = 64;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_baddr;
  logic [LW-1:0] cmd_len;
  logic          rdc_en;
  logic [AW-1:0] rdc_addr;
  logic          rdc_grnt;
  logic [DW-1:0] rdc_word;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_word;
  logic          out_last;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gdelay = 0;
  int rdy_mode = 0;

  logic [AW-1:0] gnt_addr_q[$];
  int            gnt_cyc_q[$];
  logic [DW:0]   pop_q[$];
  int            pop_cyc_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW:0]   exp_out_q[$];
  int done_cnt, done_cyc, ready_cyc, busy_cnt, en_cnt, addr_bad, hold_bad;

  mvu_rdc_reader dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_baddr(cmd_baddr), .cmd_len(cmd_len), .rdc_en(rdc_en), .rdc_addr(rdc_addr),
    .rdc_grnt(rdc_grnt), .rdc_word(rdc_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [16:0] m;
    m = 17'(a) * 17'd3;
    return {m, 15'h1234, 1'b1, ~a, 16'(a)};
  endfunction

  // Memory/sink model, sampled mid-cycle: grants after gdelay waiting cycles, returns data a cycle later.
  logic          pend, p_en, p_gnt, p_ov, p_or, p_cr;
  logic [AW-1:0] pend_addr, p_addr;
  logic [DW:0]   p_out;
  int            wait_cnt;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0; wait_cnt = 0; rdc_grnt = 1'b0;
      p_en = 1'b0; p_gnt = 1'b0; p_ov = 1'b0; p_or = 1'b1; p_cr = 1'b1;
    end else begin
      rdc_word = pend ? word_of(pend_addr) : {$urandom, $urandom};
      if (p_en && !p_gnt && rdc_addr !== p_addr) addr_bad++;
      if (p_ov && !p_or && (!out_valid || {out_last, out_word} !== p_out)) hold_bad++;
      if (!p_cr && cmd_ready) ready_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (rdc_en) en_cnt++;
      pend = 1'b0;
      if (rdc_en) begin
        if (wait_cnt >= gdelay) begin
          rdc_grnt = 1'b1; wait_cnt = 0; pend = 1'b1; pend_addr = rdc_addr;
          gnt_addr_q.push_back(rdc_addr); gnt_cyc_q.push_back(cyc);
        end else begin
          rdc_grnt = 1'b0; wait_cnt++;
        end
      end else begin
        rdc_grnt = 1'($urandom_range(0, 1));
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        pop_q.push_back({out_last, out_word}); pop_cyc_q.push_back(cyc);
      end
      p_en = rdc_en; p_gnt = rdc_grnt; p_addr = rdc_addr;
      p_ov = out_valid; p_or = out_ready; p_out = {out_last, out_word}; p_cr = cmd_ready;
    end
  end

  task automatic clear_obs();
    gnt_addr_q.delete(); gnt_cyc_q.delete(); pop_q.delete(); pop_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; ready_cyc = -1; busy_cnt = 0; en_cnt = 0;
    addr_bad = 0; hold_bad = 0;
  endtask

  // Reference stream: consecutive addresses modulo 2^AW, last tag on the final word.
  task automatic build_model(input logic [AW-1:0] ba, input logic [LW-1:0] ln);
    logic [AW-1:0] a;
    exp_addr_q.delete(); exp_out_q.delete();
    for (int i = 0; i < int'(ln); i++) begin
      a = AW'(int'(ba) + i);
      exp_addr_q.push_back(a);
      exp_out_q.push_back({1'(i == int'(ln) - 1), word_of(a)});
    end
  endtask

  task automatic issue(input logic [AW-1:0] ba, input logic [LW-1:0] ln, output int t);
    int guard = 0;
    cmd_baddr = ba; cmd_len = ln; cmd_valid = 1'b1;
    while (!cmd_ready && guard < 200) begin @(posedge clk); #2; guard++; end
    t = cyc;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input string nm);
    int guard = 0;
    while (done_cnt < n && guard < 2000) begin @(posedge clk); #2; guard++; end
    checks++;
    if (done_cnt < n) begin
      errors++; $display("FAIL %s done_timeout: done_cnt=%0d expected=%0d", nm, done_cnt, n);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_baddr = '0; cmd_len = '0; rdc_word = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    checks++;
    if ({cmd_ready, rdc_en, busy, done, out_valid, out_last} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl: got=%b expected=100000",
                         {cmd_ready, rdc_en, busy, done, out_valid, out_last});
    end
    checks++;
    if (rdc_addr !== 15'h0 || out_word !== 64'h0) begin
      errors++; $display("FAIL reset_data: addr=%h word=%h expected 0", rdc_addr, out_word);
    end
  endtask

  task automatic test_basic();
    int t;
    clear_obs(); rdy_mode = 0; gdelay = 0;
    build_model(15'h0010, 16'd4);
    issue(15'h0010, 16'd4, t);
    wait_done(1, "basic");
    checks++;
    if (pop_q.size() != 4 || gnt_addr_q.size() != 4 || done_cnt != 1) begin
      errors++; $display("FAIL basic_count: pops=%0d grants=%0d dones=%0d expected 4/4/1",
                         pop_q.size(), gnt_addr_q.size(), done_cnt);
    end
    foreach (exp_out_q[i]) if (i < pop_q.size() && i < gnt_addr_q.size()) begin
      checks++;
      if (pop_q[i] !== exp_out_q[i] || gnt_addr_q[i] !== exp_addr_q[i] || gnt_cyc_q[i] != t + 1 + i) begin
        errors++; $display("FAIL basic_word%0d: addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                           i, gnt_addr_q[i], pop_q[i], gnt_cyc_q[i], exp_addr_q[i], exp_out_q[i], t + 1 + i);
      end
    end
    if (pop_cyc_q.size() == 4) begin
      checks++;
      if (pop_cyc_q[0] != t + 3 || done_cyc != pop_cyc_q[3] + 1 || ready_cyc != done_cyc + 1) begin
        errors++; $display("FAIL basic_timing: first_pop=%0d done=%0d ready=%0d expected %0d/%0d/%0d",
                           pop_cyc_q[0], done_cyc, ready_cyc, t + 3, pop_cyc_q[3] + 1, pop_cyc_q[3] + 2);
      end
    end
    checks++;
    if (busy_cnt != done_cyc - t) begin
      errors++; $display("FAIL basic_busy: cycles=%0d expected=%0d", busy_cnt, done_cyc - t);
    end
  endtask

  task automatic test_len0();
    int t;
    logic [AW-1:0] ba;
    clear_obs(); rdy_mode = 0; gdelay = 0;
    ba = AW'($urandom);
    issue(ba, 16'd0, t);
    wait_done(1, "len0");
    checks++;
    if (en_cnt != 0 || pop_q.size() != 0 || done_cyc != t + 1 || ready_cyc != t + 2) begin
      errors++; $display("FAIL len0: en_cycles=%0d pops=%0d done=%0d ready=%0d expected 0/0/%0d/%0d",
                         en_cnt, pop_q.size(), done_cyc, ready_cyc, t + 1, t + 2);
    end
  endtask

  task automatic test_wrap();
    int t;
    clear_obs(); rdy_mode = 0; gdelay = 0;
    build_model(15'h7FFE, 16'd3);
    issue(15'h7FFE, 16'd3, t);
    wait_done(1, "wrap");
    checks++;
    if (gnt_addr_q.size() != 3 || pop_q.size() != 3) begin
      errors++; $display("FAIL wrap_count: grants=%0d pops=%0d expected 3", gnt_addr_q.size(), pop_q.size());
    end
    foreach (exp_addr_q[i]) if (i < gnt_addr_q.size() && i < pop_q.size()) begin
      checks++;
      if (gnt_addr_q[i] !== exp_addr_q[i] || pop_q[i] !== exp_out_q[i]) begin
        errors++; $display("FAIL wrap_addr%0d: addr=%h data=%h expected addr=%h data=%h",
                           i, gnt_addr_q[i], pop_q[i], exp_addr_q[i], exp_out_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    int t;
    logic [AW-1:0] ba;
    clear_obs(); rdy_mode = 1; gdelay = 0;
    ba = AW'($urandom);
    build_model(ba, 16'd8);
    issue(ba, 16'd8, t);
    repeat (15) @(posedge clk);
    #2;
    checks++;
    if (gnt_addr_q.size() != 4 || rdc_en !== 1'b0 || rdc_addr !== AW'(int'(ba) + 4)) begin
      errors++; $display("FAIL stall_credit: grants=%0d rdc_en=%b addr=%h expected 4/0/%h",
                         gnt_addr_q.size(), rdc_en, rdc_addr, AW'(int'(ba) + 4));
    end
    checks++;
    if (out_valid !== 1'b1 || {out_last, out_word} !== exp_out_q[0]) begin
      errors++; $display("FAIL stall_head: valid=%b data=%h expected 1/%h", out_valid, {out_last, out_word}, exp_out_q[0]);
    end
    rdy_mode = 0;
    wait_done(1, "stall");
    checks++;
    if (gnt_addr_q.size() != 8 || pop_q.size() != 8 || hold_bad != 0 || addr_bad != 0) begin
      errors++; $display("FAIL stall_count: grants=%0d pops=%0d hold_bad=%0d addr_bad=%0d expected 8/8/0/0",
                         gnt_addr_q.size(), pop_q.size(), hold_bad, addr_bad);
    end
    foreach (exp_out_q[i]) if (i < pop_q.size() && i < gnt_addr_q.size()) begin
      checks++;
      if (pop_q[i] !== exp_out_q[i] || gnt_addr_q[i] !== exp_addr_q[i]) begin
        errors++; $display("FAIL stall_word%0d: addr=%h data=%h expected addr=%h data=%h",
                           i, gnt_addr_q[i], pop_q[i], exp_addr_q[i], exp_out_q[i]);
      end
    end
  endtask

  task automatic test_delay();
    int t;
    int cr_seen = 0;
    logic [AW-1:0] ba;
    clear_obs(); rdy_mode = 2; gdelay = 5;
    ba = AW'($urandom);
    build_model(ba, 16'd6);
    issue(ba, 16'd6, t);
    cmd_valid = 1'b1; cmd_baddr = ~ba; cmd_len = 16'd2;
    repeat (10) begin
      if (cmd_ready) cr_seen++;
      @(posedge clk); #2;
    end
    cmd_valid = 1'b0;
    wait_done(1, "delay");
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (cr_seen != 0 || done_cnt != 1 || addr_bad != 0 || hold_bad != 0 || pop_q.size() != 6 || gnt_addr_q.size() != 6) begin
      errors++; $display("FAIL delay_ctrl: ready_busy=%0d dones=%0d addr_bad=%0d hold_bad=%0d pops=%0d grants=%0d expected 0/1/0/0/6/6",
                         cr_seen, done_cnt, addr_bad, hold_bad, pop_q.size(), gnt_addr_q.size());
    end
    foreach (exp_out_q[i]) if (i < pop_q.size() && i < gnt_addr_q.size()) begin
      checks++;
      if (pop_q[i] !== exp_out_q[i] || gnt_addr_q[i] !== exp_addr_q[i]) begin
        errors++; $display("FAIL delay_word%0d: addr=%h data=%h expected addr=%h data=%h",
                           i, gnt_addr_q[i], pop_q[i], exp_addr_q[i], exp_out_q[i]);
      end
    end
    gdelay = 0;
  endtask

  task automatic test_reset_mid();
    int t;
    logic [AW-1:0] ba;
    clear_obs(); rdy_mode = 1; gdelay = 0;
    issue(AW'($urandom), 16'd8, t);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1 || gnt_addr_q.size() != 3) begin
      errors++; $display("FAIL rstmid_pre: valid=%b grants=%0d expected 1/3", out_valid, gnt_addr_q.size());
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, rdc_en, busy, done, out_valid, out_last} !== 6'b100000 || rdc_addr !== 15'h0 || out_word !== 64'h0) begin
      errors++; $display("FAIL rstmid_clear: ctrl=%b addr=%h word=%h expected 100000/0/0",
                         {cmd_ready, rdc_en, busy, done, out_valid, out_last}, rdc_addr, out_word);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    clear_obs(); rdy_mode = 0;
    ba = AW'($urandom);
    build_model(ba, 16'd1);
    issue(ba, 16'd1, t);
    wait_done(1, "rstmid");
    checks++;
    if (pop_q.size() != 1 || gnt_addr_q.size() != 1 || done_cnt != 1) begin
      errors++; $display("FAIL rstmid_count: pops=%0d grants=%0d dones=%0d expected 1/1/1",
                         pop_q.size(), gnt_addr_q.size(), done_cnt);
    end else begin
      checks++;
      if (pop_q[0] !== exp_out_q[0] || gnt_addr_q[0] !== exp_addr_q[0]) begin
        errors++; $display("FAIL rstmid_word: addr=%h data=%h expected addr=%h data=%h",
                           gnt_addr_q[0], pop_q[0], exp_addr_q[0], exp_out_q[0]);
      end
    end
  endtask

  task automatic test_random();
    int t;
    logic [AW-1:0] ba;
    logic [LW-1:0] ln;
    for (int b = 0; b < 6; b++) begin
      clear_obs(); rdy_mode = 2; gdelay = $urandom_range(0, 2);
      ba = AW'($urandom); ln = LW'($urandom_range(1, 9));
      build_model(ba, ln);
      issue(ba, ln, t);
      wait_done(1, "random");
      checks++;
      if (pop_q.size() != int'(ln) || gnt_addr_q.size() != int'(ln) || addr_bad != 0 || hold_bad != 0 || done_cnt != 1) begin
        errors++; $display("FAIL random%0d_ctrl: pops=%0d grants=%0d addr_bad=%0d hold_bad=%0d dones=%0d expected %0d/%0d/0/0/1",
                           b, pop_q.size(), gnt_addr_q.size(), addr_bad, hold_bad, done_cnt, ln, ln);
      end
      foreach (exp_out_q[i]) if (i < pop_q.size() && i < gnt_addr_q.size()) begin
        checks++;
        if (pop_q[i] !== exp_out_q[i] || gnt_addr_q[i] !== exp_addr_q[i]) begin
          errors++; $display("FAIL random%0d_word%0d: addr=%h data=%h expected addr=%h data=%h",
                             b, i, gnt_addr_q[i], pop_q[i], exp_addr_q[i], exp_out_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_stall();
    test_delay();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
